// File: rtl/alu_seq.sv
// Handshaked ALU. Single-cycle ops register their result at the accept edge.
// MUL is an unsigned shift-add that retires one multiplier bit per cycle.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         OPCODE,
  input  logic [WIDTH-1:0]   OP1,
  input  logic [WIDTH-1:0]   OP2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] RES,
  output logic               Z,
  output logic               C,
  output logic               V,
  output logic               N
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [31:0] WLIM = WIDTH;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6, OP_SLTU = 3'd7;

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;
  typedef struct packed {
    logic [2*WIDTH-1:0] res;
    logic z, c, v, n;
  } result_t;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  result_t            out_q, out_d;
  logic               ovld_q, ovld_d;

  logic               accept, wr;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   lo;
  logic               lo_c, lo_v;
  logic [2*WIDTH-1:0] prod;

  assign in_ready = (state_q == IDLE) && (!ovld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, OP1} + {1'b0, OP2};
  // diff[WIDTH] is the unsigned borrow, shared by SUB and SLTU
  assign diff     = {1'b0, OP1} - {1'b0, OP2};
  assign prod     = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    lo   = '0;
    lo_c = 1'b0;
    lo_v = 1'b0;
    case (OPCODE)
      OP_ADD: begin
        lo   = sum[WIDTH-1:0];
        lo_c = sum[WIDTH];
        lo_v = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SUB: begin
        lo   = diff[WIDTH-1:0];
        lo_c = diff[WIDTH];
        lo_v = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_AND:  lo = OP1 & OP2;
      OP_OR:   lo = OP1 | OP2;
      OP_XOR:  lo = OP1 ^ OP2;
      OP_SHL:  lo = (32'(OP2) >= WLIM) ? '0 : (OP1 << OP2);
      OP_SLTU: lo = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: lo = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    wr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (OPCODE == OP_MUL) begin
            // bit 0 is folded in at acceptance so WIDTH-1 busy cycles remain
            state_d  = MUL_BUSY;
            cnt_d    = CW'(WIDTH - 1);
            acc_d    = OP2[0] ? {{WIDTH{1'b0}}, OP1} : '0;
            mcand_d  = {{WIDTH{1'b0}}, OP1} << 1;
            mplier_d = OP2 >> 1;
          end else begin
            wr       = 1'b1;
            out_d.res = {{WIDTH{1'b0}}, lo};
            out_d.z  = (lo == '0);
            out_d.c  = lo_c;
            out_d.v  = lo_v;
            out_d.n  = lo[WIDTH-1];
          end
        end
      end
      MUL_BUSY: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wr        = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          out_d.res = prod;
          out_d.z   = (prod == '0);
          out_d.c   = |prod[2*WIDTH-1:WIDTH];
          out_d.v   = 1'b0;
          out_d.n   = prod[2*WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
    ovld_d = wr ? 1'b1 : (out_ready ? 1'b0 : ovld_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      ovld_q   <= ovld_d;
    end
  end

  assign out_valid = ovld_q;
  assign RES       = out_q.res;
  assign Z         = out_q.z;
  assign C         = out_q.c;
  assign V         = out_q.v;
  assign N         = out_q.n;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the 4-bit `alu`. It accepts one operation per transfer on a valid/ready input port and returns a registered result plus status flags on a valid/ready output port. Single-cycle ops complete in one cycle; `MUL` is an iterative shift-add taking WIDTH cycles. The block sits between an operand/issue stage and a result consumer, and it is the formal-verification target that follows `alu`.

## Interface
Parameters:
- `WIDTH`, 4, operand width; legal range 2..32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operation present on `OPCODE`/`OP1`/`OP2`.
- `in_ready`  out  1  block can accept an operation this cycle.
- `OPCODE`  in  3  operation select (encoding below).
- `OP1`  in  WIDTH  first operand.
- `OP2`  in  WIDTH  second operand.
- `out_valid`  out  1  `RES`/flags hold a valid result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `RES`  out  2*WIDTH  result; upper WIDTH bits are zero except for `MUL`.
- `Z`, `C`, `V`, `N`  out  1 each  zero, carry/borrow, signed overflow, negative.

## Operation
- Opcodes:
  - 000 `ADD`: C = carry out; V = signed overflow.
  - 001 `SUB`: OP1−OP2; C = borrow (OP1<OP2 unsigned); V = signed overflow.
  - 010 `AND`, 011 `OR`, 100 `XOR`: C = 0, V = 0.
  - 101 `SHL`: OP1 << OP2; result is 0 if OP2 ≥ WIDTH; C = 0, V = 0.
  - 110 `MUL`: unsigned, full 2*WIDTH product.
  - 111 `SLTU`: RES = 1 if OP1<OP2 unsigned, else 0; C = 0, V = 0.
- Flags for all non-`MUL` ops: Z = (low WIDTH bits == 0); N = RES[WIDTH-1].
- Flags for `MUL`: Z = (full product == 0); C = (upper half ≠ 0); V = 0; N = RES[2*WIDTH-1].
- All arithmetic is modulo 2^WIDTH except `MUL`.
- FSM states:
  - `IDLE` → `MUL_BUSY` on acceptance of `MUL`. Acceptance is `in_valid && in_ready`.
  - `MUL_BUSY` holds a down-counter initialised to WIDTH−1. It processes one multiplier bit per cycle.
  - When the counter reaches 0, the product is written to the output register and the FSM returns to `IDLE`.
  - Non-`MUL` ops never leave `IDLE`; the result is written to the output register at the accept edge.
- `in_ready` = (state == `IDLE`) && (!`out_valid` || `out_ready`). The output register is never overwritten while its value is unconsumed.
- `out_valid`:
  - Set when a result is written.
  - Cleared on `out_ready` at an edge where no new result is written.
  - Stays set when a consume and a new write occur at the same edge.
- `RES` and the flags are stable while `out_valid && !out_ready`.
- The operands and opcode are captured at acceptance. Input changes during `MUL_BUSY` have no effect.

## Timing
- Reset: at every edge with `rst` = 1, `out_valid` = 0, `RES` = 0, Z = C = V = N = 0, state = `IDLE`, counter = 0. `in_ready` = 1 in the first cycle after `rst` deasserts.
- Reset mid-`MUL` aborts the operation; no result is produced.
- Single-cycle op accepted at edge E: `out_valid` = 1 from E until consumed. Throughput is 1 op/cycle with `out_ready` held high.
- `MUL` accepted at edge E:
  - `in_ready` = 0 for WIDTH−1 cycles, then `out_valid` = 1 after edge E+WIDTH−1.
  - Result latency is WIDTH edges from acceptance counting E. With WIDTH = 4: accept at E, result visible after E+3.
- Back-to-back: a new op is accepted at the same edge that consumes the previous result.
- Ops are not accepted while `MUL_BUSY`, even if `out_ready` = 1.
- `in_valid` with `in_ready` = 0 is ignored; it is not queued.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid` = 1 → `out_valid` = 0, `RES` = 0, flags 0. `in_ready` = 1 the cycle after release.
- `ADD` (WIDTH = 4):
  - 4'hF + 4'h1 → next cycle `RES` = 8'h00, Z = 1, C = 1, V = 0, N = 0.
  - 4'h7 + 4'h1 → `RES` = 8'h08, V = 1, N = 1, C = 0.
- `MUL` 4'hF × 4'hF → `in_ready` low during busy; after 4 edges `RES` = 8'hE1, C = 1, Z = 0, N = 1. Inputs toggled during busy do not affect the result.
- Backpressure: `SUB` 3−5 with `out_ready` = 0 → `RES` = 8'h0E, C = 1 held stable, `in_ready` = 0. Raise `out_ready` together with a pending `XOR` → accepted at the same edge, `out_valid` stays 1.
- Reset mid-`MUL`: assert `rst` in the 2nd busy cycle → `out_valid` never rises for that op; `IDLE` and `in_ready` = 1 after release.
- Edge ops: `SHL` 4'h3 by 5 → `RES` = 0, Z = 1. `SLTU` 2 < 9 → `RES` = 1. `SLTU` 9 < 2 → `RES` = 0, Z = 1.
